// File: rtl/axis_width_downsizer.sv
// AXI-Stream width downsizer: splits each SLAVE_WIDTH-byte word into RATIO narrow beats.
// Define AXIS_DOWNSIZER_BIG_ENDIAN_EN to emit the most-significant lane first.
module axis_width_downsizer #(
    parameter int SLAVE_WIDTH  = 4,
    parameter int MASTER_WIDTH = 2
) (
    input  logic                      aclk,
    input  logic                      arst,
    input  logic [SLAVE_WIDTH*8-1:0]  s_axis_tdata,
    input  logic [SLAVE_WIDTH-1:0]    s_axis_tkeep,
    input  logic                      s_axis_tlast,
    input  logic                      s_axis_tvalid,
    output logic                      s_axis_tready,
    output logic [MASTER_WIDTH*8-1:0] m_axis_tdata,
    output logic [MASTER_WIDTH-1:0]   m_axis_tkeep,
    output logic                      m_axis_tlast,
    output logic                      m_axis_tvalid,
    input  logic                      m_axis_tready
);

    localparam int RATIO   = SLAVE_WIDTH / MASTER_WIDTH;
    localparam int IDX_W   = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam int MW_BITS = MASTER_WIDTH * 8;
    localparam int SW_BITS = SLAVE_WIDTH * 8;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RATIO - 1);

    generate
        if ((SLAVE_WIDTH < MASTER_WIDTH) || ((SLAVE_WIDTH % MASTER_WIDTH) != 0)) begin : g_bad_ratio
            $error("axis_width_downsizer: SLAVE_WIDTH must be an integer multiple of MASTER_WIDTH");
        end
    endgenerate

    logic [SW_BITS-1:0]     data_r;
    logic [SLAVE_WIDTH-1:0] keep_r;
    logic                   last_r;
    logic                   full_r;
    logic [IDX_W-1:0]       idx_r;
    logic                   en_r;
    logic [IDX_W-1:0]       lane_s;
    logic                   at_last_s;
    logic                   in_xfer_s;
    logic                   out_xfer_s;

    // en_r holds ready low through reset and releases it on the first edge afterwards
    always_ff @(posedge aclk or posedge arst) begin
        if (arst) begin
            en_r <= 1'b0;
        end else begin
            en_r <= 1'b1;
        end
    end

`ifdef AXIS_DOWNSIZER_BIG_ENDIAN_EN
    assign lane_s = LAST_IDX - idx_r;
`else
    assign lane_s = idx_r;
`endif

    // Handshake qualifiers; a new word may enter as the final lane of the old one leaves
    always_comb begin
        at_last_s     = (idx_r == LAST_IDX);
        s_axis_tready = en_r && (!full_r || (m_axis_tready && at_last_s));
        in_xfer_s     = s_axis_tvalid && s_axis_tready;
        out_xfer_s    = full_r && m_axis_tready;
    end

    // Output lane selection straight from the stored word, so it is stable under backpressure
    always_comb begin
        m_axis_tvalid = full_r;
        m_axis_tdata  = data_r[int'(lane_s) * MW_BITS +: MW_BITS];
        m_axis_tkeep  = keep_r[int'(lane_s) * MASTER_WIDTH +: MASTER_WIDTH];
        m_axis_tlast  = last_r && at_last_s;
    end

    // Word register, occupancy flag and lane counter
    always_ff @(posedge aclk or posedge arst) begin
        if (arst) begin
            data_r <= '0;
            keep_r <= '0;
            last_r <= 1'b0;
            full_r <= 1'b0;
            idx_r  <= '0;
        end else if (in_xfer_s) begin
            data_r <= s_axis_tdata;
            keep_r <= s_axis_tkeep;
            last_r <= s_axis_tlast;
            full_r <= 1'b1;
            idx_r  <= '0;
        end else if (out_xfer_s) begin
            if (at_last_s) begin
                full_r <= 1'b0;
                idx_r  <= '0;
            end else begin
                idx_r  <= idx_r + IDX_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_axis_width_downsizer.sv
// Scoreboard bench for axis_width_downsizer (4-byte to 2-byte); directed cases then random traffic.
module tb_axis_width_downsizer;

    localparam int SW    = 4;
    localparam int MW    = 2;
    localparam int RATIO = SW / MW;
    localparam int MB    = MW * 8;

`ifdef AXIS_DOWNSIZER_BIG_ENDIAN_EN
    localparam logic [15:0] FIRST_BEAT = 16'h4433;
`else
    localparam logic [15:0] FIRST_BEAT = 16'h2211;
`endif

    typedef struct packed {
        logic [MB-1:0] data;
        logic [MW-1:0] keep;
        logic          last;
    } beat_t;

    logic          aclk;
    logic          arst;
    logic [SW*8-1:0] s_tdata;
    logic [SW-1:0] s_tkeep;
    logic          s_tlast;
    logic          s_tvalid;
    logic          s_tready;
    logic [MB-1:0] m_tdata;
    logic [MW-1:0] m_tkeep;
    logic          m_tlast;
    logic          m_tvalid;
    logic          m_tready;

    beat_t exp_q[$];
    int    n_checks;
    int    n_pass;
    bit    rand_rdy;
    int    valid_run;
    int    max_run;

    axis_width_downsizer #(.SLAVE_WIDTH(SW), .MASTER_WIDTH(MW)) dut (
        .aclk          (aclk),
        .arst          (arst),
        .s_axis_tdata  (s_tdata),
        .s_axis_tkeep  (s_tkeep),
        .s_axis_tlast  (s_tlast),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tready (s_tready),
        .m_axis_tdata  (m_tdata),
        .m_axis_tkeep  (m_tkeep),
        .m_axis_tlast  (m_tlast),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tready (m_tready)
    );

    initial begin
        aclk = 1'b0;
        forever #5 aclk = ~aclk;
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", name, got, exp);
    endtask

    // Reference: a wide word becomes RATIO narrow beats in emission order
    task automatic push_word(input logic [31:0] w, input logic [3:0] k, input logic l);
        for (int b = 0; b < RATIO; b++) begin
            int    lane;
            beat_t e;
`ifdef AXIS_DOWNSIZER_BIG_ENDIAN_EN
            lane = RATIO - 1 - b;
`else
            lane = b;
`endif
            e.data = MB'(w >> (lane * MB));
            e.keep = MW'(k >> (lane * MW));
            e.last = l && (b == RATIO - 1);
            exp_q.push_back(e);
        end
    endtask

    task automatic send_word(input logic [31:0] w, input logic [3:0] k, input logic l, output int waits);
        s_tdata  = w;
        s_tkeep  = k;
        s_tlast  = l;
        s_tvalid = 1'b1;
        for (waits = 0; waits < 200; waits++) begin
            @(negedge aclk);
            if (s_tready) break;
        end
        if (waits >= 200) begin
            n_checks++;
            $display("FAIL send_timeout: s_axis_tready never rose for word 0x%0h", w);
            s_tvalid = 1'b0;
        end else begin
            push_word(w, k, l);
            @(posedge aclk);
            #1;
            s_tvalid = 1'b0;
        end
    endtask

    initial begin
        forever begin
            @(posedge aclk);
            #1;
            if (rand_rdy) m_tready = ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: pops the scoreboard on each output handshake and checks stall stability
    initial begin
        beat_t cur;
        beat_t prev;
        beat_t e;
        bit    prev_stall;
        prev_stall = 1'b0;
        prev       = '0;
        forever begin
            @(negedge aclk);
            cur = '{m_tdata, m_tkeep, m_tlast};
            if (m_tvalid) valid_run++;
            else valid_run = 0;
            if (valid_run > max_run) max_run = valid_run;
            if (prev_stall && m_tvalid && !arst) chk("stall_stable", cur, prev);
            if (m_tvalid && m_tready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_beat: got data 0x%0h, required no beat", m_tdata);
                end else begin
                    e = exp_q.pop_front();
                    chk("beat_data", m_tdata, e.data);
                    chk("beat_keep", m_tkeep, e.keep);
                    chk("beat_last", m_tlast, e.last);
                end
            end
            prev_stall = m_tvalid && !m_tready && !arst;
            prev       = cur;
        end
    end

    initial begin
        int w;
        n_checks  = 0;
        n_pass    = 0;
        rand_rdy  = 1'b0;
        valid_run = 0;
        max_run   = 0;
        s_tvalid  = 1'b0;
        s_tdata   = '0;
        s_tkeep   = '0;
        s_tlast   = 1'b0;
        m_tready  = 1'b0;
        arst      = 1'b1;

        repeat (3) @(posedge aclk);
        #1;
        chk("rst_tvalid", m_tvalid, 0);
        chk("rst_tdata", m_tdata, 0);
        chk("rst_tkeep", m_tkeep, 0);
        chk("rst_tlast", m_tlast, 0);
        chk("rst_s_tready", s_tready, 0);
        @(negedge aclk);
        arst = 1'b0;
        #1;
        chk("tready_before_edge", s_tready, 0);
        @(posedge aclk);
        #1;
        chk("tready_after_edge", s_tready, 1);

        // Single word, one-cycle latency
        m_tready = 1'b1;
        send_word(32'h44332211, 4'hF, 1'b1, w);
        chk("latency_valid", m_tvalid, 1);
        chk("latency_first_beat", m_tdata, FIRST_BEAT);
        repeat (3) @(posedge aclk);
        #1;

        // Backpressure on the first beat
        m_tready = 1'b0;
        send_word(32'h44332211, 4'hF, 1'b1, w);
        repeat (3) begin
            @(negedge aclk);
            chk("bp_s_tready", s_tready, 0);
            chk("bp_tdata", m_tdata, FIRST_BEAT);
        end
        @(posedge aclk);
        #1;
        m_tready = 1'b1;
        repeat (3) @(posedge aclk);
        #1;

        // Back-to-back words with no bubble
        max_run = 0;
        send_word(32'hDDCCBBAA, 4'hF, 1'b0, w);
        send_word(32'h44332211, 4'hF, 1'b1, w);
        chk("stream_accept_wait", w, 1);
        repeat (4) @(posedge aclk);
        #1;
        chk("stream_no_bubble", max_run, 4);

        // Partial keep, including an all-zero keep slice
        send_word(32'h00332211, 4'h7, 1'b1, w);
        send_word(32'hCAFE5A5A, 4'h3, 1'b1, w);
        repeat (5) @(posedge aclk);
        #1;

        // Reset in the middle of a word
        send_word(32'h44332211, 4'hF, 1'b1, w);
        @(posedge aclk);
        #3;
        arst = 1'b1;
        #1;
        chk("midrst_tvalid", m_tvalid, 0);
        chk("midrst_tdata", m_tdata, 0);
        chk("midrst_tkeep", m_tkeep, 0);
        chk("midrst_tlast", m_tlast, 0);
        chk("midrst_s_tready", s_tready, 0);
        chk("midrst_pending", exp_q.size(), 1);
        exp_q.delete();
        @(negedge aclk);
        arst = 1'b0;
        @(posedge aclk);
        #1;
        chk("midrst_ready_back", s_tready, 1);
        repeat (5) @(posedge aclk);
        #1;
        chk("midrst_no_replay", m_tvalid, 0);

        // Random traffic with random backpressure
        rand_rdy = 1'b1;
        for (int i = 0; i < 60; i++) begin
            send_word($urandom, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), w);
            repeat ($urandom_range(0, 2)) begin
                @(posedge aclk);
                #1;
            end
        end
        @(posedge aclk);
        #1;
        rand_rdy = 1'b0;
        m_tready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            if (exp_q.size() == 0) break;
            @(posedge aclk);
            #1;
        end
        chk("drain_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
